video_timing_analyzer: RTL and testbench

Receive-side counterpart to the video timing generator. It sits on a video output bus (ce_pix, syncs, blanks, de), measures line and frame geometry, and reports when the measurement is stable across frames. It is used as a self-check monitor on the suite output and as the front end for future capture blocks.

---
 rtl/video_timing_analyzer.sv | 233 +++++++++++++++++++++++
 tb/tb_video_timing_analyzer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/video_timing_analyzer.sv
// video_timing_analyzer
// Monitors a video bus (ce_pix, syncs, de), measures line/frame geometry and
// reports when the measured geometry has repeated for LOCK_FRAMES frames.
module video_timing_analyzer #(
    parameter logic SYNC_POL    = 1'b0,
    parameter int   LOCK_FRAMES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ce_pix,
    input  logic        h_sync,
    input  logic        v_sync,
    input  logic        de,
    output logic [11:0] h_total,
    output logic [11:0] h_active,
    output logic [11:0] h_sync_width,
    output logic [11:0] v_total,
    output logic [11:0] v_active,
    output logic [11:0] v_sync_width,
    output logic        frame_strobe,
    output logic        locked,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        S_SEARCH  = 2'd0,
        S_MEASURE = 2'd1,
        S_VERIFY  = 2'd2,
        S_LOCKED  = 2'd3
    } state_t;

    localparam logic [11:0] CNT_MAX = 12'hFFF;
    localparam logic [3:0]  LOCK_N  = 4'(LOCK_FRAMES);

    function automatic logic [11:0] sat_inc(input logic [11:0] v);
        return (v == CNT_MAX) ? v : v + 12'd1;
    endfunction

    state_t      cur_st, nxt_st;

    // sampled sync levels and their previous-sample copies
    logic        hs, vs;
    logic        hs_prev, vs_prev;
    logic        hs_edge, vs_edge, timeout;

    // per-line counters over [hs_edge, next hs_edge)
    logic [11:0] dot_cnt, de_cnt, hs_cnt;
    // values of the most recently closed line
    logic [11:0] last_dot, last_hs;
    // per-frame accumulators
    logic [11:0] line_cnt, h_max, act_lines, vs_lines;

    // accumulator values after closing the current line (if one closes now)
    logic [11:0] last_dot_c, last_hs_c, line_cnt_c, h_max_c, act_c, vsl_c;
    logic [71:0] frame_tuple, ref_tuple;
    logic        tuple_match;

    logic [3:0]  match_cnt, match_nxt, match_inc;
    logic        locked_nxt, publish, load_ref;

    assign hs      = (h_sync == SYNC_POL);
    assign vs      = (v_sync == SYNC_POL);
    assign hs_edge = ce_pix & hs & ~hs_prev;
    assign vs_edge = ce_pix & vs & ~vs_prev;
    assign timeout = ce_pix & ((dot_cnt == CNT_MAX) | (line_cnt == CNT_MAX));

    // line close happens ahead of frame close, so a coincident hs_edge
    // contributes its line to the frame that is ending
    always_comb begin
        last_dot_c = last_dot;
        last_hs_c  = last_hs;
        line_cnt_c = line_cnt;
        h_max_c    = h_max;
        act_c      = act_lines;
        vsl_c      = vs_lines;
        if (hs_edge) begin
            last_dot_c = dot_cnt;
            last_hs_c  = hs_cnt;
            line_cnt_c = sat_inc(line_cnt);
            if (de_cnt > h_max) h_max_c = de_cnt;
            if (de_cnt != 12'd0) act_c = sat_inc(act_lines);
            if (vs) vsl_c = sat_inc(vs_lines);
        end
    end

    assign frame_tuple = {last_dot_c, h_max_c, last_hs_c, line_cnt_c, act_c, vsl_c};
    assign tuple_match = (frame_tuple == ref_tuple);
    assign match_inc   = match_cnt + 4'd1;

    // line and frame counters; a timeout drops everything back to zero
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hs_prev   <= 1'b1;
            vs_prev   <= 1'b1;
            dot_cnt   <= '0;
            de_cnt    <= '0;
            hs_cnt    <= '0;
            last_dot  <= '0;
            last_hs   <= '0;
            line_cnt  <= '0;
            h_max     <= '0;
            act_lines <= '0;
            vs_lines  <= '0;
        end else if (ce_pix) begin
            hs_prev <= hs;
            vs_prev <= vs;
            if (timeout) begin
                dot_cnt   <= '0;
                de_cnt    <= '0;
                hs_cnt    <= '0;
                last_dot  <= '0;
                last_hs   <= '0;
                line_cnt  <= '0;
                h_max     <= '0;
                act_lines <= '0;
                vs_lines  <= '0;
            end else begin
                if (hs_edge) begin
                    dot_cnt <= 12'd1;
                    de_cnt  <= {11'd0, de};
                    hs_cnt  <= {11'd0, hs};
                end else begin
                    dot_cnt <= sat_inc(dot_cnt);
                    if (de) de_cnt <= sat_inc(de_cnt);
                    if (hs) hs_cnt <= sat_inc(hs_cnt);
                end
                last_dot <= last_dot_c;
                last_hs  <= last_hs_c;
                if (vs_edge) begin
                    line_cnt  <= '0;
                    h_max     <= '0;
                    act_lines <= '0;
                    vs_lines  <= '0;
                end else begin
                    line_cnt  <= line_cnt_c;
                    h_max     <= h_max_c;
                    act_lines <= act_c;
                    vs_lines  <= vsl_c;
                end
            end
        end
    end

    // lock FSM: next state, publish/reference control and match counting
    always_comb begin
        nxt_st     = cur_st;
        publish    = 1'b0;
        load_ref   = 1'b0;
        match_nxt  = match_cnt;
        locked_nxt = locked;
        if (timeout) begin
            nxt_st     = S_SEARCH;
            locked_nxt = 1'b0;
            match_nxt  = '0;
        end else if (vs_edge) begin
            case (cur_st)
                S_SEARCH: begin
                    nxt_st = S_MEASURE;
                end
                S_MEASURE: begin
                    publish   = 1'b1;
                    load_ref  = 1'b1;
                    match_nxt = '0;
                    nxt_st    = S_VERIFY;
                end
                S_VERIFY: begin
                    publish = 1'b1;
                    if (tuple_match) begin
                        match_nxt = match_inc;
                        if (match_inc >= LOCK_N) begin
                            nxt_st     = S_LOCKED;
                            locked_nxt = 1'b1;
                        end
                    end else begin
                        load_ref  = 1'b1;
                        match_nxt = '0;
                    end
                end
                S_LOCKED: begin
                    publish = 1'b1;
                    if (!tuple_match) begin
                        load_ref   = 1'b1;
                        match_nxt  = '0;
                        locked_nxt = 1'b0;
                        nxt_st     = S_VERIFY;
                    end
                end
                default: nxt_st = S_SEARCH;
            endcase
        end
    end

    // FSM state, match counter, lock flag and reference tuple
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_st    <= S_SEARCH;
            match_cnt <= '0;
            locked    <= 1'b0;
            ref_tuple <= '0;
        end else if (ce_pix) begin
            cur_st    <= nxt_st;
            match_cnt <= match_nxt;
            locked    <= locked_nxt;
            if (load_ref) ref_tuple <= frame_tuple;
        end
    end

    // published measurement; strobe lasts exactly one clk regardless of ce_pix
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_total      <= '0;
            h_active     <= '0;
            h_sync_width <= '0;
            v_total      <= '0;
            v_active     <= '0;
            v_sync_width <= '0;
            frame_strobe <= 1'b0;
        end else begin
            frame_strobe <= publish;
            if (publish) begin
                h_total      <= last_dot_c;
                h_active     <= h_max_c;
                h_sync_width <= last_hs_c;
                v_total      <= line_cnt_c;
                v_active     <= act_c;
                v_sync_width <= vsl_c;
            end
        end
    end

    assign state = cur_st;

endmodule

// File: tb/tb_video_timing_analyzer.sv
// Directed bench for video_timing_analyzer using a reduced 40x20 raster
// (hs 5 dots, vs 2 lines, de 24 dots x 15 lines) so whole frames are cheap.
module tb_video_timing_analyzer;

    localparam logic SP  = 1'b0;
    localparam int   HT  = 40, HS = 5, HA0 = 8, HA = 24;
    localparam int   VS  = 2, VA0 = 3, VA = 15;
    localparam logic [71:0] G20 = {12'd40, 12'd24, 12'd5, 12'd20, 12'd15, 12'd2};
    localparam logic [71:0] G21 = {12'd40, 12'd24, 12'd5, 12'd21, 12'd15, 12'd2};

    logic clk = 1'b0, reset = 1'b1, ce_pix = 1'b0;
    logic h_sync = 1'b1, v_sync = 1'b1, de = 1'b0;
    logic [11:0] h_total, h_active, h_sync_width, v_total, v_active, v_sync_width;
    logic frame_strobe, locked;
    logic [1:0] state;
    logic [71:0] geom;
    int div = 4;
    int n_tests = 0, n_fail = 0, n_strobe = 0, base;

    video_timing_analyzer #(.SYNC_POL(SP), .LOCK_FRAMES(2)) dut (
        .clk(clk), .reset(reset), .ce_pix(ce_pix), .h_sync(h_sync), .v_sync(v_sync), .de(de),
        .h_total(h_total), .h_active(h_active), .h_sync_width(h_sync_width),
        .v_total(v_total), .v_active(v_active), .v_sync_width(v_sync_width),
        .frame_strobe(frame_strobe), .locked(locked), .state(state)
    );

    assign geom = {h_total, h_active, h_sync_width, v_total, v_active, v_sync_width};

    always #5 clk = ~clk;

    always @(negedge clk) if (frame_strobe === 1'b1) n_strobe++;

    // one pixel sample: div-1 idle clks then one clk with ce_pix high
    task automatic pix(input logic hs, input logic vs, input logic d);
        for (int k = 0; k < div; k++) begin
            @(negedge clk);
            ce_pix = (k == div - 1);
            h_sync = hs ? SP : ~SP;
            v_sync = vs ? SP : ~SP;
            de     = d;
        end
    endtask

    task automatic line(input int ln, input int d0, input int d1);
        for (int d = d0; d <= d1; d++)
            pix(d < HS, ln < VS, (ln >= VA0) && (ln < VA0 + VA) && (d >= HA0) && (d < HA0 + HA));
    endtask

    task automatic lines(input int l0, input int l1);
        for (int l = l0; l <= l1; l++) line(l, 0, HT - 1);
    endtask

    task automatic settle();
        @(negedge clk);
        ce_pix = 1'b0;
        #1;
    endtask

    // finish the current frame (line 0 sample 0 already driven) as nl lines,
    // then drive the first sample of the next frame
    task automatic frame(input int nl);
        line(0, 1, HT - 1);
        lines(1, nl - 1);
        line(0, 0, 0);
        settle();
    endtask

    task automatic do_reset();
        ce_pix = 1'b0; h_sync = ~SP; v_sync = ~SP; de = 1'b0;
        reset = 1'b1;
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic start_stream();
        for (int i = 0; i < 4; i++) pix(1'b0, 1'b0, 1'b0);
        line(0, 0, 0);
        settle();
    endtask

    task automatic test_reset();
        #20;
        if (geom !== 72'd0) begin $display("FAIL reset_geom: got %h expected 0", geom); n_fail++; end
        n_tests++;
        if (frame_strobe !== 1'b0) begin $display("FAIL reset_strobe: got %b expected 0", frame_strobe); n_fail++; end
        n_tests++;
        if (locked !== 1'b0) begin $display("FAIL reset_locked: got %b expected 0", locked); n_fail++; end
        n_tests++;
        if (state !== 2'd0) begin $display("FAIL reset_state: got %0d expected 0", state); n_fail++; end
        n_tests++;
        reset = 1'b0;
    endtask

    task automatic test_lock();
        div = 4;
        start_stream();
        if (state !== 2'd1 || frame_strobe !== 1'b0) begin
            $display("FAIL lock_search_exit: state %0d strobe %b expected 1/0", state, frame_strobe); n_fail++;
        end
        n_tests++;
        frame(20);
        if (frame_strobe !== 1'b1) begin $display("FAIL lock_p1_strobe: got %b expected 1", frame_strobe); n_fail++; end
        n_tests++;
        if (geom !== G20) begin $display("FAIL lock_p1_geom: got %h expected %h", geom, G20); n_fail++; end
        n_tests++;
        if (locked !== 1'b0 || state !== 2'd2) begin
            $display("FAIL lock_p1_state: locked %b state %0d expected 0/2", locked, state); n_fail++;
        end
        n_tests++;
        frame(20);
        if (locked !== 1'b0 || state !== 2'd2) begin
            $display("FAIL lock_p2_state: locked %b state %0d expected 0/2", locked, state); n_fail++;
        end
        n_tests++;
        frame(20);
        if (locked !== 1'b1 || state !== 2'd3) begin
            $display("FAIL lock_p3_state: locked %b state %0d expected 1/3", locked, state); n_fail++;
        end
        n_tests++;
    endtask

    task automatic test_mismatch();
        frame(21);
        if (geom !== G21) begin $display("FAIL mism_geom: got %h expected %h", geom, G21); n_fail++; end
        n_tests++;
        if (locked !== 1'b0 || state !== 2'd2) begin
            $display("FAIL mism_state: locked %b state %0d expected 0/2", locked, state); n_fail++;
        end
        n_tests++;
        frame(20);
        if (locked !== 1'b0 || v_total !== 12'd20) begin
            $display("FAIL mism_newref: locked %b v_total %0d expected 0/20", locked, v_total); n_fail++;
        end
        n_tests++;
        frame(20);
        if (locked !== 1'b0) begin $display("FAIL mism_match1: locked %b expected 0", locked); n_fail++; end
        n_tests++;
        frame(20);
        if (locked !== 1'b1 || state !== 2'd3) begin
            $display("FAIL mism_relock: locked %b state %0d expected 1/3", locked, state); n_fail++;
        end
        n_tests++;
    endtask

    task automatic test_coincident();
        base = n_strobe;
        frame(20);
        if (v_total !== 12'd20 || v_sync_width !== 12'd2) begin
            $display("FAIL coinc_vtotal: v_total %0d vsw %0d expected 20/2", v_total, v_sync_width); n_fail++;
        end
        n_tests++;
        if (n_strobe !== base + 1 || state !== 2'd3) begin
            $display("FAIL coinc_strobe: strobes %0d state %0d expected %0d/3", n_strobe - base, state, 1); n_fail++;
        end
        n_tests++;
    endtask

    task automatic test_timeout();
        div = 1;
        base = n_strobe;
        for (int i = 0; i < 4200; i++) pix(1'b0, 1'b0, 1'b0);
        settle();
        if (state !== 2'd0 || locked !== 1'b0) begin
            $display("FAIL timeout_state: state %0d locked %b expected 0/0", state, locked); n_fail++;
        end
        n_tests++;
        if (geom !== G20 || n_strobe !== base) begin
            $display("FAIL timeout_hold: got %h strobes %0d expected %h/0", geom, n_strobe - base, G20); n_fail++;
        end
        n_tests++;
    endtask

    task automatic test_reset_mid();
        div = 1;
        do_reset();
        start_stream();
        frame(20);
        if (geom !== G20) begin $display("FAIL rmid_pre_geom: got %h expected %h", geom, G20); n_fail++; end
        n_tests++;
        line(0, 1, HT - 1);
        lines(1, 9);
        line(10, 0, 19);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        if (geom !== 72'd0 || state !== 2'd0 || locked !== 1'b0 || frame_strobe !== 1'b0) begin
            $display("FAIL rmid_async: geom %h state %0d locked %b expected 0", geom, state, locked); n_fail++;
        end
        n_tests++;
        line(10, 20, 25);
        reset = 1'b0;
        base = n_strobe;
        line(10, 26, HT - 1);
        lines(11, 19);
        line(0, 0, 0);
        settle();
        if (n_strobe !== base || state !== 2'd1) begin
            $display("FAIL rmid_first_vs: strobes %0d state %0d expected 0/1", n_strobe - base, state); n_fail++;
        end
        n_tests++;
        frame(20);
        if (n_strobe !== base + 1 || geom !== G20) begin
            $display("FAIL rmid_second_vs: strobes %0d geom %h expected 1/%h", n_strobe - base, geom, G20); n_fail++;
        end
        n_tests++;
    endtask

    task automatic test_ce_gating();
        for (int r = 0; r < 2; r++) begin
            div = (r == 0) ? 1 : 3;
            do_reset();
            start_stream();
            frame(20);
            if (frame_strobe !== 1'b1 || geom !== G20) begin
                $display("FAIL ce_div%0d: strobe %b geom %h expected 1/%h", div, frame_strobe, geom, G20); n_fail++;
            end
            n_tests++;
        end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_mismatch();
        test_coincident();
        test_timeout();
        test_reset_mid();
        test_ce_gating();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
